// File: rtl/csp_buf_pkg.sv
// Shared constants and helpers for the CSP link buffer.
// Router flit width, default depth, occupancy width.
package csp_buf_pkg;

  localparam int FLIT_W    = 11;
  localparam int BUF_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/csp_buf_ptr.sv
// Wrap-at-DEPTH pointer for the CSP link buffer.
// Explicit compare so non-power-of-2 depths wrap correctly.
module csp_buf_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/csp_lsbuf_fifo.sv
// Parametrised valid/ready flit buffer between router input and crossbar.
// Occupancy, almost-full and sync flush; no same-cycle bypass.
module csp_lsbuf_fifo
  import csp_buf_pkg::*;
#(
  parameter int WIDTH    = FLIT_W,
  parameter int DEPTH    = BUF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    almost_full
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CW-1:0]    cnt_nx;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // flush wins: transfers offered in the flush cycle are dropped
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  csp_buf_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (push),
    .clr     (flush),
    .ptr     (wr_ptr)
  );

  csp_buf_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pop),
    .clr     (flush),
    .ptr     (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    cnt_nx = count;
    unique case (1'b1)
      flush:         cnt_nx = '0;
      push && !pop:  cnt_nx = count + 1'b1;
      pop  && !push: cnt_nx = count - 1'b1;
      default:       cnt_nx = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= cnt_nx;
      almost_full <= (cnt_nx >= CW'(AF_LEVEL));
    end
  end

endmodule

// File: tb/tb_csp_lsbuf_fifo.sv
// Directed bench for csp_lsbuf_fifo: DEPTH=4 and DEPTH=3 instances,
// queue scoreboards plus an occupancy model derived from queue size.
module tb_csp_lsbuf_fifo;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        flush4, in_valid4, in_ready4, out_valid4, out_ready4;
  logic        almost_full4;
  logic [10:0] in_data4, out_data4;
  logic [2:0]  count4;

  logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic        almost_full3;
  logic [10:0] in_data3, out_data3;
  logic [1:0]  count3;

  logic [10:0] q4[$];
  logic [10:0] q3[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rx3   = 0;
  logic        acc3;

  always #5 clk = ~clk;

  csp_lsbuf_fifo #(
    .WIDTH (11),
    .DEPTH (4)
  ) u_d4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush4),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .in_data     (in_data4),
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .out_data    (out_data4),
    .count       (count4),
    .almost_full (almost_full4)
  );

  csp_lsbuf_fifo #(
    .WIDTH (11),
    .DEPTH (3)
  ) u_d3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush3),
    .in_valid    (in_valid3),
    .in_ready    (in_ready3),
    .in_data     (in_data3),
    .out_valid   (out_valid3),
    .out_ready   (out_ready3),
    .out_data    (out_data3),
    .count       (count3),
    .almost_full (almost_full3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_chk();
    int s4, s3;
    s4 = q4.size();
    s3 = q3.size();
    chk("cnt4", 32'(count4), 32'(s4));
    chk("af4", 32'(almost_full4), 32'(s4 >= 3));
    chk("ird4", 32'(in_ready4), 32'(s4 != 4));
    chk("ovl4", 32'(out_valid4), 32'(s4 != 0));
    chk("cnt3", 32'(count3), 32'(s3));
    chk("af3", 32'(almost_full3), 32'(s3 >= 2));
  endtask

  // called at negedge with inputs driven; predicts transfers at next edge
  task automatic step();
    logic p4, o4, p3, o3;
    #1;
    p4   = in_valid4 && in_ready4;
    o4   = out_valid4 && out_ready4;
    p3   = in_valid3 && in_ready3;
    o3   = out_valid3 && out_ready3;
    acc3 = p3 && !flush3;
    if (flush4) begin
      q4.delete();
    end else begin
      if (o4) begin
        chk("q4_nonempty", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) begin
          chk("out4_data", 32'(out_data4), 32'(q4[0]));
          void'(q4.pop_front());
        end
      end
      if (p4) q4.push_back(in_data4);
    end
    if (flush3) begin
      q3.delete();
    end else begin
      if (o3) begin
        chk("q3_nonempty", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) begin
          chk("out3_data", 32'(out_data3), 32'(q3[0]));
          void'(q3.pop_front());
          rx3++;
        end
      end
      if (p3) q3.push_back(in_data3);
    end
    @(posedge clk);
    @(negedge clk);
    model_chk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1);
  end

  initial begin
    int idx;
    logic [10:0] seq [3];
    seq[0] = 11'h000;
    seq[1] = 11'h7FF;
    seq[2] = 11'h555;
    reset_n = 1'b0;
    {flush4, in_valid4, out_ready4} = '0;
    {flush3, in_valid3, out_ready3} = '0;
    in_data4 = '0;
    in_data3 = '0;

    // reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_ird", 32'(in_ready4), 32'd1);
    chk("rst_ovl", 32'(out_valid4), 32'd0);
    chk("rst_cnt", 32'(count4), 32'd0);
    chk("rst_af", 32'(almost_full4), 32'd0);
    chk("rst_cnt3", 32'(count3), 32'd0);
    @(negedge clk);

    // sequential transfer, out_ready held high
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid4 = 1'b1;
      in_data4  = seq[i];
      step();
      chk("seq_cnt_le1", 32'(count4 <= 3'd1), 32'd1);
      chk("seq_vis", 32'(out_valid4), 32'd1);
    end
    in_valid4 = 1'b0;
    repeat (2) step();
    chk("seq_drained", 32'(q4.size()), 32'd0);

    // fill and back-pressure
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_data4  = 11'(12'h100 + i);
      step();
    end
    chk("full_ird", 32'(in_ready4), 32'd0);
    chk("full_af", 32'(almost_full4), 32'd1);
    in_data4 = 11'h104;
    step();
    chk("stall_cnt", 32'(count4), 32'd4);
    // full with valid and ready both high: pop only
    out_ready4 = 1'b1;
    step();
    chk("full_pop_cnt", 32'(count4), 32'd3);
    out_ready4 = 1'b0;
    step();
    chk("refill_cnt", 32'(count4), 32'd4);
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    repeat (5) step();
    chk("fill_drained", 32'(q4.size()), 32'd0);

    // wrap on DEPTH=3 with random consumer stalls
    idx = 0;
    for (int c = 0; c < 400 && rx3 < 10; c++) begin
      in_valid3  = (idx < 10);
      in_data3   = 11'(idx);
      out_ready3 = 1'($urandom_range(0, 1));
      step();
      if (acc3) idx++;
    end
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;
    chk("wrap_rx", 32'(rx3), 32'd10);
    chk("wrap_q", 32'(q3.size()), 32'd0);

    // flush with count = 2 and push/pop both active
    out_ready4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid4 = 1'b1;
      in_data4  = 11'(12'h200 + i);
      step();
    end
    chk("pre_flush_cnt", 32'(count4), 32'd2);
    in_data4   = 11'h202;
    out_ready4 = 1'b1;
    flush4     = 1'b1;
    step();
    flush4    = 1'b0;
    in_valid4 = 1'b0;
    chk("flush_cnt", 32'(count4), 32'd0);
    chk("flush_ovl", 32'(out_valid4), 32'd0);
    repeat (2) step();

    // async reset between edges with count = 3
    out_ready4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid4 = 1'b1;
      in_data4  = 11'(12'h300 + i);
      step();
    end
    in_valid4 = 1'b0;
    chk("pre_rst_cnt", 32'(count4), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ird", 32'(in_ready4), 32'd1);
    chk("arst_ovl", 32'(out_valid4), 32'd0);
    chk("arst_cnt", 32'(count4), 32'd0);
    chk("arst_af", 32'(almost_full4), 32'd0);
    q4.delete();
    q3.delete();
    @(negedge clk);
    reset_n    = 1'b1;
    out_ready4 = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
